// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with valid/ready handshakes.
//
// Stage 1 captures an accepted operand set. Stage 2 computes the result and
// flags from the stage-1 operands and holds them until the consumer retires
// them. Both stages can advance in the same cycle, so a result can retire and
// a new operand set can be accepted together without a bubble.
//
// Parameters
//   WIDTH  operand/result width (power of two, 4..64)
//   SHW    shift-amount width, taken from B[SHW-1:0]
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    operand set A/B/Op/sign is presented
//   in_ready    block accepts operands this cycle
//   A, B        operands
//   Op          000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL,
//               110 SRA, 111 reserved
//   sign        1 = two's-complement, 0 = unsigned (ADD/SUB flags)
//   out_valid   result fields valid
//   out_ready   consumer takes the result this cycle
//   Out         result
//   Ofl         overflow / carry / borrow
//   Z           result is zero
//   resultSign  true sign of the result
//   err         reserved opcode was issued
//
// Build option
//   ALU_PIPE_SAT_EN  when defined, overflowing ADD/SUB clamp to the
//                    representable limit instead of wrapping.
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Z,
  output logic             resultSign,
  output logic             err
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  localparam int MSB = WIDTH - 1;

  // Stage-1 operand registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_sign;

  logic             s2_valid;

  logic             s1_load;
  logic             s2_load;

  // Stage-2 next-value signals computed from stage-1 operands
  logic [WIDTH:0]          add_full;
  logic [WIDTH:0]          sub_full;
  logic                    add_sovf;
  logic                    sub_sovf;
  logic                    sub_borrow;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] a_signed;

  logic [WIDTH-1:0] res_next;
  logic             ofl_next;
  logic             z_next;
  logic             rsign_next;
  logic             err_next;

  // Handshake: stage 2 takes a new result when it is empty or its current
  // result is retiring; stage 1 may refill in the same cycle it hands off,
  // which is what keeps the pipeline at one result per cycle.
  assign s2_load   = s1_valid & (~s2_valid | out_ready);
  assign in_ready  = ~s1_valid | s2_load;
  assign s1_load   = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Arithmetic with one extra bit so the carry-out is visible. SUB is
  // A + ~B + 1; its carry-out is 1 exactly when no borrow occurred.
  assign add_full   = {1'b0, s1_a} + {1'b0, s1_b};
  assign sub_full   = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH+1)'(1);
  assign sub_borrow = ~sub_full[WIDTH];

  // Signed overflow: operands that can overflow (same sign for ADD,
  // differing signs for SUB) produce a result whose sign differs from A.
  assign add_sovf = (s1_a[MSB] == s1_b[MSB]) & (add_full[MSB] != s1_a[MSB]);
  assign sub_sovf = (s1_a[MSB] != s1_b[MSB]) & (sub_full[MSB] != s1_a[MSB]);

  assign shamt    = s1_b[SHW-1:0];
  assign a_signed = s1_a;

  // Result and flag selection. For signed ADD/SUB the true sign is the
  // wrapped MSB corrected by the overflow bit; it is taken from the wrapped
  // value so that saturation does not disturb it.
  always_comb begin
    res_next   = '0;
    ofl_next   = 1'b0;
    rsign_next = 1'b0;
    err_next   = 1'b0;
    z_next     = 1'b0;

    case (s1_op)
      OP_ADD: begin
        res_next   = add_full[MSB:0];
        ofl_next   = s1_sign ? add_sovf : add_full[WIDTH];
        rsign_next = s1_sign ? (add_full[MSB] ^ add_sovf) : 1'b0;
      end
      OP_SUB: begin
        res_next   = sub_full[MSB:0];
        ofl_next   = s1_sign ? sub_sovf : sub_borrow;
        rsign_next = s1_sign ? (sub_full[MSB] ^ sub_sovf) : sub_borrow;
      end
      OP_AND: begin
        res_next   = s1_a & s1_b;
        rsign_next = res_next[MSB];
      end
      OP_OR: begin
        res_next   = s1_a | s1_b;
        rsign_next = res_next[MSB];
      end
      OP_XOR: begin
        res_next   = s1_a ^ s1_b;
        rsign_next = res_next[MSB];
      end
      OP_SLL: begin
        res_next   = s1_a << shamt;
        rsign_next = res_next[MSB];
      end
      OP_SRA: begin
        res_next   = a_signed >>> shamt;
        rsign_next = res_next[MSB];
      end
      default: begin
        err_next = 1'b1;
      end
    endcase

`ifdef ALU_PIPE_SAT_EN
    // Clamp overflowing ADD/SUB. A signed overflow always has the true
    // result on the same side of zero as A, so A's sign picks the limit.
    if ((s1_op == OP_ADD || s1_op == OP_SUB) && ofl_next) begin
      if (s1_sign)
        res_next = s1_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        res_next = (s1_op == OP_ADD) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    end
`else
    // Wrapping arithmetic: the modulo result selected above stands.
`endif

    z_next = (res_next == '0);
  end

  // Pipeline registers. Reset drops both valids (and any same-cycle accept)
  // and clears the visible result fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= OP_ADD;
      s1_sign    <= 1'b0;
      s2_valid   <= 1'b0;
      Out        <= '0;
      Ofl        <= 1'b0;
      Z          <= 1'b0;
      resultSign <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_a     <= A;
        s1_b     <= B;
        s1_op    <= op_e'(Op);
        s1_sign  <= sign;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        s2_valid   <= 1'b1;
        Out        <= res_next;
        Ofl        <= ofl_next;
        Z          <= z_next;
        resultSign <= rsign_next;
        err        <= err_next;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH=16).
// Expected results come from an arithmetic reference model; accepted
// operand sets are queued in order and compared against every cycle the
// DUT shows out_valid, so a stalled result must match the queue head too.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   Op;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Out;
  logic         Ofl;
  logic         Z;
  logic         resultSign;
  logic         err;

  int checks    = 0;
  int failures  = 0;
  int accepted  = 0;
  int retired   = 0;

  typedef struct packed {
    logic [W-1:0] out;
    logic         ofl;
    logic         z;
    logic         rs;
    logic         err;
  } res_t;

  res_t exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .Op         (Op),
    .sign       (sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Out        (Out),
    .Ofl        (Ofl),
    .Z          (Z),
    .resultSign (resultSign),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: computes the true mathematical result with wide
  // integers and derives the flags from range checks.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic sgn);
    res_t   r;
    longint ua, ub, sa, sb, t, maxs, mins, maxu;
    int     sh;
    r    = '0;
    maxu = (longint'(1) << W) - 1;
    maxs = (longint'(1) << (W - 1)) - 1;
    mins = -(maxs + 1);
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (ua > maxs) ? ua - (maxu + 1) : ua;
    sb   = (ub > maxs) ? ub - (maxu + 1) : ub;
    sh   = int'(ub % W);
    t    = 0;
    case (op)
      3'd0, 3'd1: begin
        if (sgn) t = (op == 3'd0) ? sa + sb : sa - sb;
        else     t = (op == 3'd0) ? ua + ub : ua - ub;
        if (sgn) r.ofl = (t > maxs) || (t < mins);
        else     r.ofl = (t > maxu) || (t < 0);
        r.out = W'(t);
        if (sgn) r.rs = (t < 0);
        else     r.rs = (op == 3'd1) && (t < 0);
`ifdef ALU_PIPE_SAT_EN
        if (r.ofl) begin
          if (sgn)            r.out = (t > maxs) ? W'(maxs) : W'(mins);
          else if (op == 3'd0) r.out = W'(maxu);
          else                 r.out = '0;
        end
`endif
      end
      3'd2: r.out = a & b;
      3'd3: r.out = a | b;
      3'd4: r.out = a ^ b;
      3'd5: r.out = W'(ua << sh);
      3'd6: r.out = W'(sa >>> sh);
      default: r.err = 1'b1;
    endcase
    if (op >= 3'd2 && op <= 3'd6) r.rs = r.out[W-1];
    r.z = (r.out == '0);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    assert (actual === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, sample at the falling edge, compare any
  // visible result with the queue head, record retire/accept, then step.
  task automatic applyStimulus(input logic v, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [2:0] op,
                               input logic sg, input logic rdy);
    in_valid  = v;
    A         = a;
    B         = b;
    Op        = op;
    sign      = sg;
    out_ready = rdy;
    @(negedge clk);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin
        checkOutput("Out",        64'(Out),        64'(exp_q[0].out));
        checkOutput("Ofl",        64'(Ofl),        64'(exp_q[0].ofl));
        checkOutput("Z",          64'(Z),          64'(exp_q[0].z));
        checkOutput("resultSign", 64'(resultSign), 64'(exp_q[0].rs));
        checkOutput("err",        64'(err),        64'(exp_q[0].err));
        if (out_ready) begin
          void'(exp_q.pop_front());
          retired++;
        end
      end
    end
    if (rst) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, op, sg));
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, '0, '0, 3'd0, 1'b0, rdy);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; A = '0; B = '0; Op = '0; sign = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    idle(1'b0);

    // Reset state
    checkOutput("rst_out_valid",  64'(out_valid),  64'(0));
    checkOutput("rst_Out",        64'(Out),        64'(0));
    checkOutput("rst_Ofl",        64'(Ofl),        64'(0));
    checkOutput("rst_Z",          64'(Z),          64'(0));
    checkOutput("rst_resultSign", 64'(resultSign), 64'(0));
    checkOutput("rst_err",        64'(err),        64'(0));
    rst = 1'b0;
    checkOutput("in_ready_after_rst", 64'(in_ready), 64'(1));

    // SUB 5-5 signed: two-cycle latency and zero result
    applyStimulus(1'b1, 16'h0005, 16'h0005, 3'd1, 1'b1, 1'b1);
    checkOutput("lat_cycle1_out_valid", 64'(out_valid), 64'(0));
    idle(1'b1);
    checkOutput("lat_cycle2_out_valid", 64'(out_valid), 64'(1));
    checkOutput("sub_zero_Out", 64'(Out), 64'(16'h0000));
    checkOutput("sub_zero_Z",   64'(Z),   64'(1));
    checkOutput("sub_zero_Ofl", 64'(Ofl), 64'(0));
    checkOutput("sub_zero_rs",  64'(resultSign), 64'(0));
    idle(1'b1);

    // SUB 0-5 unsigned: borrow
    applyStimulus(1'b1, 16'h0000, 16'h0005, 3'd1, 1'b0, 1'b1);
    idle(1'b1);
`ifdef ALU_PIPE_SAT_EN
    checkOutput("sub_borrow_Out", 64'(Out), 64'(16'h0000));
    checkOutput("sub_borrow_Z",   64'(Z),   64'(1));
`else
    checkOutput("sub_borrow_Out", 64'(Out), 64'(16'hFFFB));
    checkOutput("sub_borrow_Z",   64'(Z),   64'(0));
    checkOutput("sub_borrow_rs",  64'(resultSign), 64'(1));
`endif
    checkOutput("sub_borrow_Ofl", 64'(Ofl), 64'(1));
    idle(1'b1);

    // ADD 0x7FFF+1 signed: overflow
    applyStimulus(1'b1, 16'h7FFF, 16'h0001, 3'd0, 1'b1, 1'b1);
    idle(1'b1);
`ifdef ALU_PIPE_SAT_EN
    checkOutput("add_ovf_Out", 64'(Out), 64'(16'h7FFF));
`else
    checkOutput("add_ovf_Out", 64'(Out), 64'(16'h8000));
`endif
    checkOutput("add_ovf_Ofl", 64'(Ofl), 64'(1));
    checkOutput("add_ovf_rs",  64'(resultSign), 64'(0));
    idle(1'b1);

    // Reserved op followed back-to-back by SRA
    applyStimulus(1'b1, 16'h1234, 16'h5678, 3'd7, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h8000, 16'h0003, 3'd6, 1'b0, 1'b1);
    checkOutput("rsv_err", 64'(err), 64'(1));
    checkOutput("rsv_Out", 64'(Out), 64'(0));
    checkOutput("rsv_Z",   64'(Z),   64'(1));
    idle(1'b1);
    checkOutput("sra_Out", 64'(Out), 64'(16'hF000));
    checkOutput("sra_err", 64'(err), 64'(0));
    checkOutput("sra_rs",  64'(resultSign), 64'(1));
    idle(1'b1);

    // Fill both stages while stalled, then reset for one cycle
    applyStimulus(1'b1, 16'h1111, 16'h2222, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 16'h4444, 3'd0, 1'b0, 1'b0);
    checkOutput("full_in_ready",  64'(in_ready),  64'(0));
    checkOutput("full_out_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    applyStimulus(1'b1, 16'h5555, 16'h6666, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("post_rst_in_ready",  64'(in_ready),  64'(1));
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Sustained throughput: one accept every cycle
    accepted = 0;
    retired  = 0;
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom), 1'b1);
    checkOutput("stream_accepted", 64'(accepted), 64'(20));

    // Random SUBs with random back-pressure
    for (int i = 0; i < 1000; i++)
      applyStimulus(1'($urandom), W'($urandom), W'($urandom), 3'd1,
                    1'($urandom), 1'($urandom));

    // Random mix of every opcode
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom), W'($urandom), W'($urandom),
                    3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));

    // Drain with a bounded cycle budget
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));
    checkOutput("retired_eq_accepted", 64'(retired), 64'(accepted));
    idle(1'b1);
    checkOutput("final_out_valid", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
